// File: rtl/parity_arbiter_pkg.sv
// Shared types and constants for the parity arbiter: FSM state encoding,
// default sizing and the error-counter ceiling.
package parity_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         NREQ_DEF    = 4;
  localparam int         W_DEF       = 9;
  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/parity_arbiter_parity_calc.sv
// Shared parity resource: XOR reduction of one W-bit word (1 = odd parity).
module parity_calc
  import parity_arbiter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] word,
  output logic         odd
);

  // XOR over every bit, data and parity alike
  assign odd = ^word;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one parity checker among NREQ requesters.
// Optional saturating parity-error counter enabled by macro PARITY_ERR_CNT_EN.
module parity_arbiter
  import parity_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic                    res_ok
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]              err_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);

  state_t          state_r;
  state_t          state_next_s;
  logic [IDW-1:0]  ptr_r;
  logic [IDW-1:0]  winner_s;
  logic [NREQ-1:0] grant_s;
  logic            found_s;
  logic            xfer_s;
  int              idx_s;
  logic [W-1:0]    word_r;
  logic [IDW-1:0]  id_r;
  logic            res_ok_r;
  logic            res_valid_r;
  logic            odd_s;

  parity_calc #(.W(W)) u_parity_calc (
    .word (word_r),
    .odd  (odd_s)
  );

  // Round-robin search: first asserted req_valid starting at the pointer
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    idx_s    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(ptr_r) + k) % NREQ;
      if (!found_s && req_valid[IDW'(idx_s)]) begin
        found_s  = 1'b1;
        winner_s = IDW'(idx_s);
      end else begin
        found_s  = found_s;
      end
    end
    if (found_s) begin
      grant_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      grant_s = '0;
    end
  end

  // Next-state decode and grant output; grants only in IDLE and out of reset
  always_comb begin
    state_next_s = state_r;
    req_ready    = '0;
    xfer_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (rst_n) begin
          req_ready = grant_s;
          xfer_s    = found_s;
        end else begin
          req_ready = '0;
          xfer_s    = 1'b0;
        end
        if (xfer_s) begin
          state_next_s = CHECK;
        end else begin
          state_next_s = IDLE;
        end
      end
      CHECK: state_next_s = DONE;
      DONE: begin
        if (res_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM, capture registers and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      word_r      <= '0;
      id_r        <= '0;
      res_ok_r    <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (xfer_s) begin
        word_r <= req_data[winner_s*W +: W];
        id_r   <= winner_s;
        ptr_r  <= (winner_s == IDW'(NREQ-1)) ? '0 : winner_s + IDW'(1);
      end
      if (state_r == CHECK) begin
        res_ok_r    <= ~odd_s;
        res_valid_r <= 1'b1;
      end else if ((state_r == DONE) && res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_r;
  assign res_id    = id_r;
  assign res_ok    = res_ok_r;

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Count rejected words as the consumer accepts them, holding at the ceiling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if ((state_r == DONE) && res_ready && !res_ok_r && (err_cnt_r != ERR_CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed bench for parity_arbiter with a transaction-level reference model
// and a per-cycle compare process.
module tb_parity_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 9;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_id;
  logic              res_ok;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  logic [W-1:0] lane [NREQ];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int dut_glog [$];
  int dut_gcyc [$];

  parity_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_ok    (res_ok)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb req_data = {lane[3], lane[2], lane[1], lane[0]};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_grant(input int p, input logic [3:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (v[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  // Reference model: a single outstanding transaction aged in cycles
  int m_ptr, m_age, m_id, m_err;
  bit m_busy, m_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_age = 0; m_id = 0; m_err = 0; m_busy = 0; m_ok = 0;
    end else if (m_busy) begin
      if (m_age >= 2 && res_ready) begin
        if (!m_ok && m_err < 255) m_err++;
        m_busy = 0;
      end else begin
        m_age++;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!m_busy && req_valid[i]) begin
          m_busy = 1;
          m_age  = 1;
          m_id   = i;
          m_ok   = ($countones(lane[i]) % 2) == 0;
          m_ptr  = (i + 1) % NREQ;
        end
      end
    end
  end

  // Compare DUT against model just before every rising edge
  always @(negedge clk) begin
    logic [3:0] eg;
    bit ev;
    #3;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
    end else begin
      eg = m_busy ? 4'b0000 : exp_grant(m_ptr, req_valid);
      ev = m_busy && (m_age >= 2);
      chk("req_ready", req_ready, eg);
      chk("res_valid", res_valid, ev);
      if (ev) begin
        chk("res_id", res_id, m_id);
        chk("res_ok", res_ok, m_ok);
      end
`ifdef PARITY_ERR_CNT_EN
      chk("err_cnt", err_cnt, m_err);
`endif
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_glog.push_back(i);
        dut_gcyc.push_back(cyc);
      end
      if (res_valid && res_ready) acc_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int target;
    int guard;
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) lane[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_id", res_id, 0);
    chk("reset_res_ok", res_ok, 0);
    chk("reset_req_ready", req_ready, 0);
`ifdef PARITY_ERR_CNT_EN
    chk("reset_err_cnt", err_cnt, 0);
`endif
    step();

    // Single requester, even word
    lane[0] = 9'b000011000; req_valid = 4'b0001; res_ready = 1'b1;
    #1 chk("t030_grant", req_ready, 4'b0001);
    step(); req_valid = 4'b0000;
    chk("t030_check_res_valid", res_valid, 0);
    step();
    chk("t030_res_valid", res_valid, 1);
    chk("t030_res_id", res_id, 0);
    chk("t030_res_ok", res_ok, 1);
    step();
    chk("t030_idle_res_valid", res_valid, 0);

    // Odd word from requester 1
    lane[1] = 9'b000111011; req_valid = 4'b0010;
    #1 chk("t031_grant", req_ready, 4'b0010);
    step(); req_valid = 4'b0000;
    step();
    chk("t031_res_id", res_id, 1);
    chk("t031_res_ok", res_ok, 0);
`ifdef PARITY_ERR_CNT_EN
    chk("t031_err_before", err_cnt, 0);
`endif
    step();
`ifdef PARITY_ERR_CNT_EN
    chk("t031_err_after", err_cnt, 1);
`endif

    // All four requesting continuously from a fresh pointer
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    for (int i = 0; i < NREQ; i++) lane[i] = 9'b000000011;
    dut_glog.delete(); dut_gcyc.delete();
    req_valid = 4'b1111;
    repeat (14) step();
    req_valid = 4'b0000;
    repeat (4) step();
    chk("t032_count", dut_glog.size() >= 5, 1);
    if (dut_glog.size() >= 5) begin
      chk("t032_g0", dut_glog[0], 0);
      chk("t032_g1", dut_glog[1], 1);
      chk("t032_g2", dut_glog[2], 2);
      chk("t032_g3", dut_glog[3], 3);
      chk("t032_g4", dut_glog[4], 0);
      for (int i = 1; i < 5; i++) chk("t032_gap", dut_gcyc[i] - dut_gcyc[i-1], 3);
    end

    // Backpressure in DONE; pointer is now 1
    lane[1] = 9'b000000111; res_ready = 1'b0; req_valid = 4'b1111;
    #1 chk("t033_grant", req_ready, 4'b0010);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t033_hold_valid", res_valid, 1);
      chk("t033_hold_id", res_id, 1);
      chk("t033_hold_ok", res_ok, 0);
      chk("t033_hold_ready", req_ready, 0);
      step();
    end
    res_ready = 1'b1;
    step();
    chk("t033_next_grant", req_ready, 4'b0100);

    // Reset while requester 2's word is in CHECK
    step();
    rst_n = 1'b0;
    #1 chk("t035_rst_res_valid", res_valid, 0);
    chk("t035_rst_ready", req_ready, 0);
    step(); rst_n = 1'b1;
    #1 chk("t035_res_valid", res_valid, 0);
    chk("t035_first_grant", req_ready, 4'b0001);
    step(); req_valid = 4'b0000;
    chk("t035_no_pulse", res_valid, 0);
    step();
    chk("t035_res_valid_new", res_valid, 1);
    chk("t035_res_id_new", res_id, 0);
    step();

    // Stream of odd words to saturate the error counter
    for (int i = 0; i < NREQ; i++) lane[i] = 9'b000000001;
    target = acc_cnt + 300;
    guard = 0;
    req_valid = 4'b1111;
    while (acc_cnt < target && guard < 3000) begin
      step();
      guard++;
    end
    req_valid = 4'b0000;
    repeat (4) step();
    chk("t034_done", acc_cnt >= target, 1);
`ifdef PARITY_ERR_CNT_EN
    chk("t034_err_sat", err_cnt, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
